// File: rtl/cpu_pkg.sv
// Shared constants, forwarding-source encoding and the ID/EX bundle
// for the operand issue stage.
package cpu_pkg;

  localparam int DATA_W  = 64;
  localparam int RADDR_W = 5;
  localparam int CTRL_W  = 8;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_src_e;

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic               is_load;
    logic [RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
  } id_ex_t;

endpackage

// File: rtl/operand_issue_stage_if.sv
// ID-side, register-bank, bypass and EX-side signals of the issue stage.
// slave: the stage itself; master: the surrounding pipeline.
interface operand_issue_stage_if;
  import cpu_pkg::*;

  logic               id_valid;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RADDR_W-1:0] id_rd;
  logic               id_wr;
  logic               id_is_load;
  logic [CTRL_W-1:0]  id_ctrl;
  logic [RADDR_W-1:0] rf_addr_a;
  logic [RADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0]  rf_data_a;
  logic [DATA_W-1:0]  rf_data_b;
  logic [DATA_W-1:0]  ex_res;
  logic [RADDR_W-1:0] mem_rd;
  logic               mem_wr;
  logic [DATA_W-1:0]  mem_res;
  logic [RADDR_W-1:0] wb_rd;
  logic               wb_wr;
  logic [DATA_W-1:0]  wb_res;
  logic               ex_hold;
  logic               flush;
  logic               stall;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_op_a;
  logic [DATA_W-1:0]  ex_op_b;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_wr;
  logic               ex_is_load;
  logic [CTRL_W-1:0]  ex_ctrl;

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_wr, id_is_load, id_ctrl,
    output rf_addr_a, rf_addr_b,
    input  rf_data_a, rf_data_b,
    input  ex_res,
    input  mem_rd, mem_wr, mem_res,
    input  wb_rd, wb_wr, wb_res,
    input  ex_hold, flush,
    output stall,
    output ex_valid, ex_op_a, ex_op_b,
    output ex_rd, ex_wr, ex_is_load, ex_ctrl
  );

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_wr, id_is_load, id_ctrl,
    input  rf_addr_a, rf_addr_b,
    output rf_data_a, rf_data_b,
    output ex_res,
    output mem_rd, mem_wr, mem_res,
    output wb_rd, wb_wr, wb_res,
    output ex_hold, flush,
    input  stall,
    input  ex_valid, ex_op_a, ex_op_b,
    input  ex_rd, ex_wr, ex_is_load, ex_ctrl
  );

endinterface

// File: rtl/operand_issue_stage_fwd_mux.sv
// Per-operand bypass select: youngest in-flight producer wins, else bank.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [DATA_W-1:0]  rf_data_i,
  input  logic               ex_valid_i,
  input  logic               ex_wr_i,
  input  logic               ex_is_load_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  input  logic [DATA_W-1:0]  ex_res_i,
  input  logic               mem_wr_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0]  mem_res_i,
  input  logic               wb_wr_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]  wb_res_i,
  output logic [DATA_W-1:0]  data_o
);

  fwd_src_e src;

  // A load in EX has no data yet; the hazard logic stalls for it instead.
  always_comb begin
    src = FWD_RF;
    if (ex_valid_i && ex_wr_i && !ex_is_load_i
        && ex_rd_i == rs_i)
      src = FWD_EX;
    else if (mem_wr_i && mem_rd_i == rs_i)
      src = FWD_MEM;
    else if (wb_wr_i && wb_rd_i == rs_i)
      src = FWD_WB;
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (src)
      FWD_EX:  data_o = ex_res_i;
      FWD_MEM: data_o = mem_res_i;
      FWD_WB:  data_o = wb_res_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/operand_issue_stage.sv
// ID/EX stage: bank addressing, operand bypass, load-use stall, flush.
// Optional perf counters under ISSUE_PERF_CNT_EN.
module operand_issue_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  operand_issue_stage_if.slave bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  id_ex_t            ex_q;
  id_ex_t            ex_d;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hz;

  assign bus.rf_addr_a = bus.id_rs1;
  assign bus.rf_addr_b = bus.id_rs2;

  fwd_mux u_fwd_a (
    .rs_i         (bus.id_rs1),
    .rf_data_i    (bus.rf_data_a),
    .ex_valid_i   (ex_q.valid),
    .ex_wr_i      (ex_q.wr),
    .ex_is_load_i (ex_q.is_load),
    .ex_rd_i      (ex_q.rd),
    .ex_res_i     (bus.ex_res),
    .mem_wr_i     (bus.mem_wr),
    .mem_rd_i     (bus.mem_rd),
    .mem_res_i    (bus.mem_res),
    .wb_wr_i      (bus.wb_wr),
    .wb_rd_i      (bus.wb_rd),
    .wb_res_i     (bus.wb_res),
    .data_o       (op_a)
  );

  fwd_mux u_fwd_b (
    .rs_i         (bus.id_rs2),
    .rf_data_i    (bus.rf_data_b),
    .ex_valid_i   (ex_q.valid),
    .ex_wr_i      (ex_q.wr),
    .ex_is_load_i (ex_q.is_load),
    .ex_rd_i      (ex_q.rd),
    .ex_res_i     (bus.ex_res),
    .mem_wr_i     (bus.mem_wr),
    .mem_rd_i     (bus.mem_rd),
    .mem_res_i    (bus.mem_res),
    .wb_wr_i      (bus.wb_wr),
    .wb_rd_i      (bus.wb_rd),
    .wb_res_i     (bus.wb_res),
    .data_o       (op_b)
  );

  assign hz = bus.id_valid && ex_q.valid
           && ex_q.is_load && ex_q.wr
           && ((bus.id_use_rs1 && ex_q.rd == bus.id_rs1)
            || (bus.id_use_rs2 && ex_q.rd == bus.id_rs2));

  assign bus.stall = (hz || bus.ex_hold) && !bus.flush;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush || (!bus.ex_hold && hz)) begin
      ex_d.valid   = 1'b0;
      ex_d.wr      = 1'b0;
      ex_d.is_load = 1'b0;
    end else if (!bus.ex_hold) begin
      ex_d.valid   = bus.id_valid;
      ex_d.wr      = bus.id_wr && bus.id_valid;
      ex_d.is_load = bus.id_is_load;
      ex_d.rd      = bus.id_rd;
      ex_d.ctrl    = bus.id_ctrl;
      ex_d.op_a    = op_a;
      ex_d.op_b    = op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_wr      = ex_q.wr;
  assign bus.ex_is_load = ex_q.is_load;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.ex_op_a    = ex_q.op_a;
  assign bus.ex_op_b    = ex_q.op_b;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz && !bus.flush && !bus.ex_hold
          && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush && bus.id_valid
          && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed + random bench for operand_issue_stage against a
// producer-list reference model.
module tb_operand_issue_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   pass = 0;
  int   total = 0;

  operand_issue_stage_if bus ();

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  operand_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference state of the EX register
  logic        m_valid, m_wr, m_load;
  logic [4:0]  m_rd;
  logic [7:0]  m_ctrl;
  logic [63:0] m_a, m_b;
  int unsigned m_scnt, m_fcnt;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_load = 0;
    m_rd = 0; m_ctrl = 0; m_a = 0; m_b = 0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  // Value of register rs as the ID instruction should see it: walk the
  // in-flight writers youngest first, fall back to the bank read.
  function automatic logic [63:0] ref_operand(logic [4:0] rs,
                                              logic [63:0] bank);
    logic [4:0]  who[$];
    logic [63:0] val[$];
    if (m_valid && m_wr && !m_load) begin
      who.push_back(m_rd); val.push_back(bus.ex_res);
    end
    if (bus.mem_wr) begin
      who.push_back(bus.mem_rd); val.push_back(bus.mem_res);
    end
    if (bus.wb_wr) begin
      who.push_back(bus.wb_rd); val.push_back(bus.wb_res);
    end
    foreach (who[i]) if (who[i] == rs) return val[i];
    return bank;
  endfunction

  function automatic bit ref_hz();
    bit reads;
    reads = (bus.id_use_rs1 && bus.id_rs1 == m_rd)
         || (bus.id_use_rs2 && bus.id_rs2 == m_rd);
    return bus.id_valid && m_valid && m_load && m_wr && reads;
  endfunction

  task automatic tick();
    bit          hz, st;
    logic [63:0] a, b;
    hz = ref_hz();
    a  = ref_operand(bus.id_rs1, bus.rf_data_a);
    b  = ref_operand(bus.id_rs2, bus.rf_data_b);
    st = (hz || bus.ex_hold) && !bus.flush;
    #1;
    chk("stall", 64'(bus.stall), 64'(st));
    chk("rf_addr_a", 64'(bus.rf_addr_a), 64'(bus.id_rs1));
    chk("rf_addr_b", 64'(bus.rf_addr_b), 64'(bus.id_rs2));
    @(posedge clk);
    if (hz && !bus.flush && !bus.ex_hold) m_scnt++;
    if (bus.flush && bus.id_valid) m_fcnt++;
    if (bus.flush || (!bus.ex_hold && hz)) begin
      m_valid = 0; m_wr = 0; m_load = 0;
    end else if (!bus.ex_hold) begin
      m_valid = bus.id_valid;
      m_wr    = bus.id_wr && bus.id_valid;
      m_load  = bus.id_is_load;
      m_rd    = bus.id_rd;
      m_ctrl  = bus.id_ctrl;
      m_a     = a;
      m_b     = b;
    end
    #1;
    chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
    chk("ex_wr", 64'(bus.ex_wr), 64'(m_wr));
    chk("ex_is_load", 64'(bus.ex_is_load), 64'(m_load));
    if (m_valid) begin
      chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
      chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
      chk("ex_op_a", bus.ex_op_a, m_a);
      chk("ex_op_b", bus.ex_op_b, m_b);
    end
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_stall", 64'(perf_stall_cnt), 64'(m_scnt));
    chk("perf_flush", 64'(perf_flush_cnt), 64'(m_fcnt));
`endif
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_rd = 0; bus.id_wr = 0; bus.id_is_load = 0;
    bus.id_ctrl = 0; bus.rf_data_a = 0; bus.rf_data_b = 0;
    bus.ex_res = 0; bus.mem_rd = 0; bus.mem_wr = 0;
    bus.mem_res = 0; bus.wb_rd = 0; bus.wb_wr = 0;
    bus.wb_res = 0; bus.ex_hold = 0; bus.flush = 0;
  endtask

  // bank model: register i reads back value i
  task automatic issue(logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, logic wr, logic ld);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = 1; bus.id_use_rs2 = 1;
    bus.id_rd = rd; bus.id_wr = wr; bus.id_is_load = ld;
    bus.id_ctrl = 8'($urandom);
    bus.rf_data_a = 64'(rs1);
    bus.rf_data_b = 64'(rs2);
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_op_a", bus.ex_op_a, 64'd0);
    chk("rst_ctrl", 64'(bus.ex_ctrl), 64'd0);
    rst_n = 1;

    // plain issue
    issue(3, 4, 5, 1, 0);
    tick();
    chk("plain_a", bus.ex_op_a, 64'd3);
    chk("plain_b", bus.ex_op_b, 64'd4);
    chk("plain_rd", 64'(bus.ex_rd), 64'd5);

    // EX forward, then EX beats MEM
    issue(1, 2, 3, 1, 0);
    tick();
    bus.ex_res = 64'h100;
    issue(3, 1, 3, 1, 0);
    tick();
    chk("fwd_ex", bus.ex_op_a, 64'h100);
    bus.mem_wr = 1; bus.mem_rd = 3; bus.mem_res = 64'h200;
    issue(3, 1, 9, 1, 0);
    tick();
    chk("fwd_ex_over_mem", bus.ex_op_a, 64'h100);

    // WB same-cycle bypass
    bus.mem_wr = 0;
    bus.wb_wr = 1; bus.wb_rd = 7; bus.wb_res = 64'hDEAD;
    issue(1, 7, 9, 1, 0);
    tick();
    chk("fwd_wb", bus.ex_op_b, 64'hDEAD);
    bus.wb_wr = 0;

    // load-use: one bubble, then MEM forward
    issue(1, 1, 2, 1, 1);
    tick();
    issue(2, 1, 6, 1, 0);
    #1 chk("lu_stall", 64'(bus.stall), 64'd1);
    tick();
    chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
    bus.mem_wr = 1; bus.mem_rd = 2; bus.mem_res = 64'h55AA;
    #1 chk("lu_release", 64'(bus.stall), 64'd0);
    tick();
    chk("lu_op", bus.ex_op_a, 64'h55AA);
    chk("lu_valid", 64'(bus.ex_valid), 64'd1);
    bus.mem_wr = 0;

    // flush beats hazard, then hold freezes EX
    issue(1, 1, 4, 1, 1);
    tick();
    issue(4, 1, 8, 1, 0);
    bus.flush = 1;
    #1 chk("fl_stall", 64'(bus.stall), 64'd0);
    tick();
    chk("fl_valid", 64'(bus.ex_valid), 64'd0);
    bus.flush = 0;
    issue(1, 2, 10, 1, 0);
    tick();
    bus.ex_hold = 1;
    issue(3, 3, 11, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", 64'(bus.stall), 64'd1);
      tick();
      chk("hold_op_a", bus.ex_op_a, 64'd1);
      chk("hold_rd", 64'(bus.ex_rd), 64'd10);
    end
    bus.ex_hold = 0;

    // async reset between edges
    issue(1, 2, 3, 1, 0);
    tick();
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(bus.ex_valid), 64'd0);
    chk("arst_op_a", bus.ex_op_a, 64'd0);
    model_reset();
`ifdef ISSUE_PERF_CNT_EN
    chk("arst_scnt", 64'(perf_stall_cnt), 64'd0);
    chk("arst_fcnt", 64'(perf_flush_cnt), 64'd0);
`endif
    #1 rst_n = 1;
    issue(1, 1, 2, 1, 1); tick();
    issue(2, 2, 3, 1, 0); tick();
    issue(1, 1, 5, 1, 1); tick();
    issue(5, 1, 6, 1, 0); tick();
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_two", 64'(perf_stall_cnt), 64'd2);
`endif

    // random traffic over a small register window
    for (int n = 0; n < 400; n++) begin
      bus.id_valid   = 1'($urandom_range(0, 3) != 0);
      bus.id_rs1     = 5'($urandom_range(0, 3));
      bus.id_rs2     = 5'($urandom_range(0, 3));
      bus.id_use_rs1 = 1'($urandom);
      bus.id_use_rs2 = 1'($urandom);
      bus.id_rd      = 5'($urandom_range(0, 3));
      bus.id_wr      = 1'($urandom);
      bus.id_is_load = 1'($urandom_range(0, 2) == 0);
      bus.id_ctrl    = 8'($urandom);
      bus.rf_data_a  = {$urandom, $urandom};
      bus.rf_data_b  = {$urandom, $urandom};
      bus.ex_res     = {$urandom, $urandom};
      bus.mem_rd     = 5'($urandom_range(0, 3));
      bus.mem_wr     = 1'($urandom);
      bus.mem_res    = {$urandom, $urandom};
      bus.wb_rd      = 5'($urandom_range(0, 3));
      bus.wb_wr      = 1'($urandom);
      bus.wb_res     = {$urandom, $urandom};
      bus.ex_hold    = 1'($urandom_range(0, 5) == 0);
      bus.flush      = 1'($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/operand_issue_stage.md
Name: operand_issue_stage

Overview:
- ID/EX pipeline stage of the 5-stage CPU; sits directly downstream of the 32x64 register bank.
- Drives the bank's two read addresses from the decoded instruction and bypasses stale read data with forwarded EX/MEM/WB results.
- Detects load-use hazards (stall + bubble), handles branch flush, and registers operands and control into the EX stage.

Parameters:
DATA_W, 64, operand/result width
RADDR_W, 5, register index width (32 registers)
CTRL_W, 8, opaque decoded-control bundle passed to EX

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid decoded instruction
id_rs1  in  RADDR_W  source A index
id_rs2  in  RADDR_W  source B index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  RADDR_W  destination index
id_wr  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_W  decoded control
rf_addr_a  out  RADDR_W  bank read address A (= id_rs1, combinational)
rf_addr_b  out  RADDR_W  bank read address B (= id_rs2, combinational)
rf_data_a  in  DATA_W  bank read data A (combinational read)
rf_data_b  in  DATA_W  bank read data B
ex_res  in  DATA_W  current ALU result of the instruction in EX
mem_rd, mem_wr, mem_res  in  RADDR_W/1/DATA_W  MEM-stage destination, write flag, result
wb_rd, wb_wr, wb_res  in  RADDR_W/1/DATA_W  WB-stage write (same values driven to bank c/w/dataC)
ex_hold  in  1  EX cannot accept; freeze this stage
flush  in  1  branch resolved taken; kill the instruction in ID
stall  out  1  hold IF/ID this cycle (combinational)
ex_valid, ex_op_a, ex_op_b, ex_rd, ex_wr, ex_is_load, ex_ctrl  out  registered EX bundle

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_wr=0, ex_is_load=0, ex_op_a=ex_op_b=0, ex_rd=0, ex_ctrl=0. Mid-operation reset discards the in-flight instruction immediately.
- Operand select, per source, priority high to low:
  - EX: ex_valid & ex_wr & !ex_is_load & ex_rd==rs -> ex_res.
  - MEM: mem_wr & mem_rd==rs -> mem_res.
  - WB: wb_wr & wb_rd==rs -> wb_res. Needed because the bank writes at posedge, so a same-cycle read returns the old value.
  - Otherwise: rf_data.
  - Register 0 is an ordinary register; no zero special-case.
- Load-use hazard: hz = id_valid & ex_valid & ex_is_load & ex_wr & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- stall = (hz | ex_hold) & !flush.
- Register update each posedge, priority order:
  1. flush=1: ex_valid<=0, ex_wr<=0, ex_is_load<=0. Flush beats hold and hazard.
  2. ex_hold=1: all ex_* hold their values.
  3. hz=1: bubble. ex_valid<=0, ex_wr<=0, ex_is_load<=0; other fields don't-care but held.
  4. Otherwise: capture the id_* bundle and the selected operands; ex_valid<=id_valid; ex_wr<=id_wr&id_valid.
- Latency: 1 cycle from ID to EX outputs. A load followed by a dependent instruction costs exactly 1 bubble.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on cycles where hz & !flush & !ex_hold.
  - perf_flush_cnt increments on cycles where flush & id_valid.
  - Both saturate at 0xFFFFFFFF and reset to 0 on rst_n.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: DATA_W, RADDR_W, CTRL_W constants; a forwarding-source enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB).
- One sub-module, fwd_mux: combinational per-operand source select, instantiated twice.
- Hazard logic and pipeline register stay in the top module.

Test Plan:
- Plain issue: reg bank r3=3, r4=4; issue rs1=3, rs2=4, rd=5, no hazards -> next cycle ex_op_a=3, ex_op_b=4, ex_valid=1, ex_rd=5.
- EX forward: in-EX ALU op rd=3, ex_res=0x100; next instr reads r3 -> ex_op_a=0x100. Repeat with mem_rd=3 also writing 0x200 -> EX still wins with 0x100.
- WB same-cycle bypass: wb_wr=1, wb_rd=7, wb_res=0xDEAD while ID reads r7 (bank still returns 7) -> ex_op_b=0xDEAD.
- Load-use: load rd=2 in EX, ID reads r2 -> stall=1 for one cycle, ex_valid=0 bubble. Next cycle the load is in MEM, the instruction issues with op=mem_res, and stall=0.
- Flush during stall: hz=1 and flush=1 same cycle -> stall=0, ex_valid=0. Then assert ex_hold for 3 cycles -> ex_* outputs constant, stall=1.
- Async reset mid-stream: drop rst_n between edges -> ex_valid=0 immediately. With ISSUE_PERF_CNT_EN, counters read 0, and after 2 load-use bubbles perf_stall_cnt=2.
